// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer.
// Holds the operator key encodings, the sequencer state encoding and the
// default datapath width used by calc_seq and calc_iter_unit.
package calc_pkg;

    localparam int unsigned DEFAULT_W = 8;

    // Operator key codes as presented on the op input.
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        StEnterA,
        StEnterB,
        StExec,
        StShow,
        StErr
    } state_e;

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative multiply/divide unit for the calculator.
// MUL: shift-add into a 2W-bit product, one multiplier bit per cycle.
// DIV: restoring division, one quotient bit per cycle, quotient only.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   start         pulse on the first execute cycle; operands sampled here
//   abort         drops any running operation
//   mode          0 = MUL, 1 = DIV
//   a, b          operands (DIV: a / b)
//   result        W-bit result, valid while done is high
//   ovf           MUL product does not fit in W bits (valid with done)
//   dz            divide by zero (raised together with done on the start cycle)
//   done          high in the cycle the final step completes
module calc_iter_unit import calc_pkg::*; #(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         dz,
    output logic         done
);

    localparam int unsigned CntW = $clog2(W);

    logic            run_q, run_d;
    logic            mode_q, mode_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;  // MUL: partial product, DIV: remainder
    logic [2*W-1:0]  opd_q, opd_d;  // MUL: shifted multiplicand, DIV: divisor
    logic [W-1:0]    sh_q, sh_d;    // MUL: multiplier, DIV: dividend -> quotient

    logic            cur_mode;
    logic [2*W-1:0]  cur_acc, cur_opd, nxt_acc, nxt_opd;
    logic [W-1:0]    cur_sh, nxt_sh;
    logic [W:0]      rem_sh, trial;
    logic            last;

    // The start cycle performs step 0 straight from the operand inputs, so a
    // full operation occupies exactly W cycles including the start cycle.
    always_comb begin
        cur_mode = start ? mode : mode_q;
        cur_acc  = start ? '0 : acc_q;
        cur_opd  = start ? {{W{1'b0}}, (mode ? b : a)} : opd_q;
        cur_sh   = start ? (mode ? a : b) : sh_q;

        rem_sh   = {cur_acc[W-1:0], cur_sh[W-1]};
        // Top bit of trial is the borrow: set when the shifted remainder < divisor.
        trial    = rem_sh - {1'b0, cur_opd[W-1:0]};

        if (cur_mode) begin
            nxt_acc = {{W{1'b0}}, (trial[W] ? rem_sh[W-1:0] : trial[W-1:0])};
            nxt_opd = cur_opd;
            nxt_sh  = {cur_sh[W-2:0], ~trial[W]};
        end else begin
            nxt_acc = cur_acc + (cur_sh[0] ? cur_opd : '0);
            nxt_opd = cur_opd << 1;
            nxt_sh  = cur_sh >> 1;
        end
    end

    assign last   = run_q && (cnt_q == CntW'(W - 1));
    assign dz     = start && mode && (b == '0);
    assign done   = !abort && (dz || last);
    assign result = cur_mode ? nxt_sh : nxt_acc[W-1:0];
    assign ovf    = !cur_mode && (nxt_acc[2*W-1:W] != '0);

    always_comb begin
        run_d  = run_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opd_d  = opd_q;
        sh_d   = sh_q;
        if (abort) begin
            run_d = 1'b0;
        end else if (start) begin
            mode_d = mode;
            if (!dz) begin
                run_d = 1'b1;
                cnt_d = CntW'(1);
                acc_d = nxt_acc;
                opd_d = nxt_opd;
                sh_d  = nxt_sh;
            end
        end else if (run_q) begin
            cnt_d = cnt_q + CntW'(1);
            acc_d = nxt_acc;
            opd_d = nxt_opd;
            sh_d  = nxt_sh;
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q  <= 1'b0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            opd_q  <= '0;
            sh_q   <= '0;
        end else begin
            run_q  <= run_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opd_q  <= opd_d;
            sh_q   <= sh_d;
        end
    end

endmodule

// File: rtl/calc_seq.sv
// Calculator control sequencer.
// Turns one-cycle key pulses into operand entry, operator selection and
// execution on an unsigned W-bit datapath. ADD/SUB finish in one execute
// cycle; MUL/DIV are delegated to calc_iter_unit and take W cycles.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   digit_valid   digit key pulse, digit = key value (10..15 ignored)
//   op_valid      operator key pulse, op = 0 ADD, 1 SUB, 2 MUL, 3 DIV
//   eq_valid      equals key pulse
//   clr           synchronous clear pulse (highest priority)
//   disp          registered display value
//   busy          high while executing
//   done          one-cycle pulse on the first result/error cycle
//   err           high while in the error state
module calc_seq import calc_pkg::*; #(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         digit_valid,
    input  logic [3:0]   digit,
    input  logic         op_valid,
    input  logic [1:0]   op,
    input  logic         eq_valid,
    input  logic         clr,
    output logic [W-1:0] disp,
    output logic         busy,
    output logic         done,
    output logic         err
);

    state_e       state_q, state_d;
    op_e          opr_q, opr_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
    logic         busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic         start_q, start_d;  // first execute cycle marker

    logic [W+3:0] a_new, b_new;
    logic         digit_ok, a_ok, b_ok;
    logic [W:0]   sum;

    logic         iter_start, iter_ovf, iter_dz, iter_done;
    logic [W-1:0] iter_result;

    // 10*x + digit as (x << 3) + (x << 1) + digit, wide enough never to wrap.
    assign digit_ok = (digit < 4'd10);
    assign a_new    = ({4'b0, a_q} << 3) + ({4'b0, a_q} << 1) + (W+4)'(digit);
    assign b_new    = ({4'b0, b_q} << 3) + ({4'b0, b_q} << 1) + (W+4)'(digit);
    assign a_ok     = digit_ok && (a_new[W+3:W] == 4'd0);
    assign b_ok     = digit_ok && (b_new[W+3:W] == 4'd0);
    assign sum      = {1'b0, a_q} + {1'b0, b_q};

    assign iter_start = start_q && (state_q == StExec) && (opr_q == OP_MUL || opr_q == OP_DIV);

    calc_iter_unit #(
        .W (W)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .abort  (clr),
        .mode   (opr_q == OP_DIV),
        .a      (a_q),
        .b      (b_q),
        .result (iter_result),
        .ovf    (iter_ovf),
        .dz     (iter_dz),
        .done   (iter_done)
    );

    // Next-state and register updates. Only the highest-priority key acts.
    always_comb begin
        state_d = state_q;
        opr_d   = opr_q;
        a_d     = a_q;
        b_d     = b_q;
        start_d = 1'b0;

        if (clr) begin
            state_d = StEnterA;
            opr_d   = OP_ADD;
            a_d     = '0;
            b_d     = '0;
        end else begin
            unique case (state_q)
                StEnterA: begin
                    if (eq_valid) begin
                        // equals before an operator does nothing
                    end else if (op_valid) begin
                        opr_d   = op_e'(op);
                        b_d     = '0;
                        state_d = StEnterB;
                    end else if (digit_valid && a_ok) begin
                        a_d = a_new[W-1:0];
                    end
                end
                StEnterB: begin
                    if (eq_valid) begin
                        state_d = StExec;
                        start_d = 1'b1;
                    end else if (op_valid) begin
                        opr_d = op_e'(op);
                    end else if (digit_valid && b_ok) begin
                        b_d = b_new[W-1:0];
                    end
                end
                StExec: begin
                    case (opr_q)
                        OP_ADD: begin
                            if (sum[W]) begin
                                state_d = StErr;
                            end else begin
                                a_d     = sum[W-1:0];
                                state_d = StShow;
                            end
                        end
                        OP_SUB: begin
                            if (a_q < b_q) begin
                                state_d = StErr;
                            end else begin
                                a_d     = a_q - b_q;
                                state_d = StShow;
                            end
                        end
                        default: begin
                            if (iter_done) begin
                                if (iter_ovf || iter_dz) begin
                                    state_d = StErr;
                                end else begin
                                    a_d     = iter_result;
                                    state_d = StShow;
                                end
                            end
                        end
                    endcase
                end
                StShow: begin
                    if (eq_valid) begin
                        // repeated equals is ignored
                    end else if (op_valid) begin
                        opr_d   = op_e'(op);
                        b_d     = '0;
                        state_d = StEnterB;
                    end else if (digit_valid && digit_ok) begin
                        a_d     = W'(digit);
                        state_d = StEnterA;
                    end
                end
                StErr: begin
                    // only clr leaves the error state
                end
                default: begin
                    state_d = StEnterA;
                end
            endcase
        end
    end

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        disp_d = disp_q;
        unique case (state_d)
            StEnterA, StShow: disp_d = a_d;
            StEnterB:         disp_d = b_d;
            StErr:            disp_d = '0;
            default:          disp_d = disp_q;
        endcase
        busy_d = (state_d == StExec);
        err_d  = (state_d == StErr);
        done_d = (state_q == StExec) && (state_d == StShow || state_d == StErr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEnterA;
            opr_q   <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            start_q <= 1'b0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opr_q   <= opr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            start_q <= start_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign disp = disp_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule
